// File: rtl/module_control.sv
// -----------------------------------------------------------------------------
// module_control
//
// Instruction sequencer for a small CPU. It waits for the execute button,
// latches the instruction fields and then steps through decode, register
// read, ALU calculation, register write/clear and display. It handshakes with
// the ALU and the display controller at each step.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   power        1 = CPU on, 0 = CPU off (forces OFF on the next edge)
//   send         execute button level; a rising edge starts an instruction
//   instruction  [17:15] opcode, [14:11] dst, [10:7] src1, [6:3] src2,
//                [6] sign, [5:0] imm
//   decoded      ALU decode-done handshake
//   calculated   ALU calc-done handshake
//   lcdDone      display-done handshake
//   stateCPU     current state (OFF=0 .. STORE=6)
//   opcode, sinalImm, Imm, addrDst, addrSrc1, addrSrc2
//                instruction fields latched when an instruction starts
//   ramWe        one-cycle register-file write strobe (in STORE)
//   ramClear     one-cycle clear-all strobe (in STORE, CLEAR opcode)
//   lcdStart     one-cycle display start strobe (first SHOW cycle)
//   busy         1 in every state except OFF and FETCH
//   error        sticky handshake timeout flag, cleared by the next start
//
// Every output comes straight from a flop. The strobes and busy are computed
// from the next state so that they line up with the registered stateCPU.
// -----------------------------------------------------------------------------
module module_control #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power,
    input  logic        send,
    input  logic [17:0] instruction,
    input  logic        decoded,
    input  logic        calculated,
    input  logic        lcdDone,
    output logic [2:0]  stateCPU,
    output logic [2:0]  opcode,
    output logic        sinalImm,
    output logic [5:0]  Imm,
    output logic [3:0]  addrDst,
    output logic [3:0]  addrSrc1,
    output logic [3:0]  addrSrc2,
    output logic        ramWe,
    output logic        ramClear,
    output logic        lcdStart,
    output logic        busy,
    output logic        error
);
    // The counter never has to hold more than TIMEOUT-1: the state is left
    // on the cycle it would reach TIMEOUT.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [2:0] {
        S_OFF    = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_READ   = 3'b011,
        S_CALC   = 3'b100,
        S_SHOW   = 3'b101,
        S_STORE  = 3'b110
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic               send_prev_reg;
    logic               error_reg, error_next;
    logic               latch_fields;
    logic               send_edge;
    logic               timeout_hit;
    logic               waiting;

    logic [2:0]         opcode_reg;
    logic               sign_reg;
    logic [5:0]         imm_reg;
    logic [3:0]         dst_reg, src1_reg, src2_reg;
    logic               ram_we_reg, ram_we_next;
    logic               ram_clear_reg, ram_clear_next;
    logic               lcd_start_reg, lcd_start_next;
    logic               busy_reg, busy_next;

    // Next-state logic. power=0 overrides everything, including a handshake
    // or timeout arriving in the same cycle.
    always_comb begin
        state_next   = state_reg;
        error_next   = error_reg;
        latch_fields = 1'b0;
        send_edge    = send & ~send_prev_reg;
        timeout_hit  = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

        if (!power) begin
            state_next = S_OFF;
        end else begin
            case (state_reg)
                S_OFF:    state_next = S_FETCH;
                S_FETCH: begin
                    // Edges seen in any other state are simply not looked at,
                    // so they are dropped rather than queued.
                    if (send_edge) begin
                        state_next   = S_DECODE;
                        latch_fields = 1'b1;
                        error_next   = 1'b0;
                    end
                end
                S_DECODE: begin
                    if (decoded) begin
                        state_next = S_READ;
                    end else if (timeout_hit) begin
                        state_next = S_FETCH;
                        error_next = 1'b1;
                    end
                end
                S_READ:   state_next = S_CALC;
                S_CALC: begin
                    if (calculated) begin
                        state_next = (opcode_reg == OP_DISPLAY) ? S_SHOW : S_STORE;
                    end else if (timeout_hit) begin
                        state_next = S_FETCH;
                        error_next = 1'b1;
                    end
                end
                S_STORE:  state_next = S_SHOW;
                S_SHOW: begin
                    if (lcdDone) begin
                        state_next = S_FETCH;
                    end else if (timeout_hit) begin
                        state_next = S_FETCH;
                        error_next = 1'b1;
                    end
                end
                default:  state_next = S_OFF;
            endcase
        end
    end

    // Wait counter and registered-output precompute.
    always_comb begin
        waiting = (state_reg == S_DECODE) || (state_reg == S_CALC) ||
                  (state_reg == S_SHOW);

        if (state_next != state_reg) begin
            wait_cnt_next = '0;
        end else if (waiting) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_next = wait_cnt_reg;
        end

        ram_we_next    = (state_next == S_STORE) && (opcode_reg != OP_CLEAR);
        ram_clear_next = (state_next == S_STORE) && (opcode_reg == OP_CLEAR);
        lcd_start_next = (state_next == S_SHOW) && (state_reg != S_SHOW);
        busy_next      = (state_next != S_OFF) && (state_next != S_FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_OFF;
            wait_cnt_reg  <= '0;
            send_prev_reg <= 1'b0;
            error_reg     <= 1'b0;
            opcode_reg    <= '0;
            sign_reg      <= 1'b0;
            imm_reg       <= '0;
            dst_reg       <= '0;
            src1_reg      <= '0;
            src2_reg      <= '0;
            ram_we_reg    <= 1'b0;
            ram_clear_reg <= 1'b0;
            lcd_start_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            send_prev_reg <= send;
            error_reg     <= error_next;
            ram_we_reg    <= ram_we_next;
            ram_clear_reg <= ram_clear_next;
            lcd_start_reg <= lcd_start_next;
            busy_reg      <= busy_next;
            // Fields hold until the next instruction start; OFF leaves them.
            if (latch_fields) begin
                opcode_reg <= instruction[17:15];
                dst_reg    <= instruction[14:11];
                src1_reg   <= instruction[10:7];
                src2_reg   <= instruction[6:3];
                sign_reg   <= instruction[6];
                imm_reg    <= instruction[5:0];
            end
        end
    end

    assign stateCPU = state_reg;
    assign opcode   = opcode_reg;
    assign sinalImm = sign_reg;
    assign Imm      = imm_reg;
    assign addrDst  = dst_reg;
    assign addrSrc1 = src1_reg;
    assign addrSrc2 = src2_reg;
    assign ramWe    = ram_we_reg;
    assign ramClear = ram_clear_reg;
    assign lcdStart = lcd_start_reg;
    assign busy     = busy_reg;
    assign error    = error_reg;

endmodule

// File: tb/tb_module_control.sv
// -----------------------------------------------------------------------------
// tb_module_control
//
// Testbench for module_control. For each instruction a per-cycle expected
// trace (state, lcdStart, error) plus the handshake stimulus is built from
// the handshake delays: a wait state lasts delay+1 cycles when the delay is
// below TIMEOUT, otherwise exactly TIMEOUT cycles followed by FETCH with
// error set. Strobes, busy and latched fields are derived from that trace.
// -----------------------------------------------------------------------------
module tb_module_control;
    localparam int TIMEOUT = 15;
    localparam logic [2:0] ST_OFF = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_READ = 3'd3, ST_CALC = 3'd4, ST_SHOW = 3'd5,
                           ST_STORE = 3'd6;

    logic        clk = 1'b0;
    logic        rst, power, send, decoded, calculated, lcdDone;
    logic [17:0] instruction;
    logic [2:0]  stateCPU, opcode;
    logic        sinalImm;
    logic [5:0]  Imm;
    logic [3:0]  addrDst, addrSrc1, addrSrc2;
    logic        ramWe, ramClear, lcdStart, busy, error;

    int total = 0;
    int bad   = 0;
    logic err_model = 1'b0;

    typedef struct packed {
        logic [2:0] st;
        logic       ls;
        logic       err;
        logic       snd;
        logic       dec;
        logic       calc;
        logic       lcd;
    } step_t;
    step_t q[$];

    module_control #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .power(power), .send(send),
        .instruction(instruction), .decoded(decoded), .calculated(calculated),
        .lcdDone(lcdDone), .stateCPU(stateCPU), .opcode(opcode),
        .sinalImm(sinalImm), .Imm(Imm), .addrDst(addrDst),
        .addrSrc1(addrSrc1), .addrSrc2(addrSrc2), .ramWe(ramWe),
        .ramClear(ramClear), .lcdStart(lcdStart), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [28:0] fields_of(input logic [17:0] ins);
        // {opcode, sign, imm, dst, src1, src2}
        return {ins[17:15], ins[6], ins[5:0], ins[14:11], ins[10:7], ins[6:3]};
    endfunction

    task automatic push(input logic [2:0] st, input logic ls, input logic err,
                        input logic snd, input logic dec, input logic calc,
                        input logic lcd);
        step_t s;
        s.st = st; s.ls = ls; s.err = err; s.snd = snd;
        s.dec = dec; s.calc = calc; s.lcd = lcd;
        q.push_back(s);
    endtask

    // One handshake wait phase; the handshake is pulsed at index d only.
    task automatic push_wait(input logic [2:0] st, input int d, input bit held,
                             output bit timed_out);
        int n;
        n = (d < TIMEOUT) ? d + 1 : TIMEOUT;
        for (int i = 0; i < n; i++) begin
            logic hs, dv, cv, lv, sv;
            hs = (i == d);
            dv = rb(); cv = rb(); lv = rb();
            if (st == ST_DECODE) dv = hs;
            if (st == ST_CALC)   cv = hs;
            if (st == ST_SHOW)   lv = hs;
            sv = held ? 1'b1 : rb();
            push(st, (st == ST_SHOW) && (i == 0), 1'b0, sv, dv, cv, lv);
        end
        timed_out = (d >= TIMEOUT);
    endtask

    task automatic build_model(input logic [17:0] ins, input int dd, input int dc,
                               input int dl, input bit held);
        bit to;
        q.delete();
        push(ST_FETCH, 1'b0, err_model, 1'b1, rb(), rb(), rb());
        push_wait(ST_DECODE, dd, held, to);
        if (!to) begin
            push(ST_READ, 1'b0, 1'b0, held ? 1'b1 : rb(), rb(), rb(), rb());
            push_wait(ST_CALC, dc, held, to);
            if (!to) begin
                if (ins[17:15] != 3'b111)
                    push(ST_STORE, 1'b0, 1'b0, held ? 1'b1 : rb(), rb(), rb(), rb());
                push_wait(ST_SHOW, dl, held, to);
            end
        end
        err_model = to;
        for (int i = 0; i < 3; i++)
            push(ST_FETCH, 1'b0, err_model, held && (i < 2), rb(), rb(), rb());
    endtask

    task automatic test_reset();
        rst = 1'b1; power = 1'b1; send = 1'b0; decoded = 1'b1;
        calculated = 1'b1; lcdDone = 1'b1; instruction = 18'h3FFFF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (stateCPU !== ST_OFF) begin
            bad++; $display("FAIL reset_state got=%0d exp=%0d", stateCPU, ST_OFF);
        end
        total++;
        if ({ramWe, ramClear, lcdStart, busy, error} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {ramWe, ramClear, lcdStart, busy, error});
        end
        total++;
        if ({opcode, sinalImm, Imm, addrDst, addrSrc1, addrSrc2} !== 29'b0) begin
            bad++; $display("FAIL reset_fields got=%h exp=0", {opcode, sinalImm, Imm, addrDst, addrSrc1, addrSrc2});
        end
        rst = 1'b0; decoded = 1'b0; calculated = 1'b0; lcdDone = 1'b0;
        @(posedge clk); #1;
        total++;
        if (stateCPU !== ST_FETCH) begin
            bad++; $display("FAIL reset_to_fetch got=%0d exp=%0d", stateCPU, ST_FETCH);
        end
        power = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if (stateCPU !== ST_OFF) begin
                bad++; $display("FAIL power_off_hold cyc=%0d got=%0d exp=%0d", i, stateCPU, ST_OFF);
            end
        end
        power = 1'b1;
        @(posedge clk); #1;
        total++;
        if (stateCPU !== ST_FETCH) begin
            bad++; $display("FAIL power_on got=%0d exp=%0d", stateCPU, ST_FETCH);
        end
        $display("reset: done, total=%0d", total);
    endtask

    task automatic test_instructions();
        logic [17:0] ins;
        int dd, dc, dl;
        bit held;
        for (int n = 0; n < 40; n++) begin
            int exp_we_n, obs_we_n, exp_ls_n, obs_ls_n;
            case (n)
                0: begin ins = 18'b001_0011_0001_0010_101; dd = 2;  dc = 2;  dl = 3;  held = 0; end
                1: begin ins = 18'b111_0000_0101_1001_011; dd = 1;  dc = 1;  dl = 0;  held = 0; end
                2: begin ins = 18'b110_1111_0000_0110_110; dd = 0;  dc = 0;  dl = 1;  held = 0; end
                3: begin ins = 18'b011_0100_0010_0011_001; dd = 0;  dc = 15; dl = 0;  held = 0; end
                4: begin ins = 18'b001_0001_0001_0001_111; dd = 0;  dc = 0;  dl = 0;  held = 0; end
                5: begin ins = 18'b010_0110_0111_1000_010; dd = 14; dc = 14; dl = 14; held = 0; end
                6: begin ins = 18'b100_1010_1011_1100_001; dd = 1;  dc = 1;  dl = 1;  held = 1; end
                7: begin ins = 18'b101_0010_0100_0110_100; dd = 15; dc = 0;  dl = 0;  held = 0; end
                8: begin ins = 18'b111_1100_0011_0101_010; dd = 0;  dc = 0;  dl = 15; held = 0; end
                default: begin
                    ins  = 18'($urandom());
                    dd   = $urandom_range(0, TIMEOUT + 1);
                    dc   = $urandom_range(0, TIMEOUT + 1);
                    dl   = $urandom_range(0, TIMEOUT + 1);
                    held = ($urandom_range(0, 3) == 0);
                end
            endcase
            build_model(ins, dd, dc, dl, held);
            exp_we_n = 0; obs_we_n = 0; exp_ls_n = 0; obs_ls_n = 0;
            for (int k = 0; k < q.size(); k++) begin
                step_t e;
                logic exp_we, exp_clr, exp_busy;
                e = q[k];
                exp_we   = (e.st == ST_STORE) && (ins[17:15] != 3'b110);
                exp_clr  = (e.st == ST_STORE) && (ins[17:15] == 3'b110);
                exp_busy = (e.st != ST_OFF) && (e.st != ST_FETCH);
                exp_we_n += int'(exp_we); obs_we_n += int'(ramWe);
                exp_ls_n += int'(e.ls);   obs_ls_n += int'(lcdStart);
                total++;
                if (stateCPU !== e.st) begin
                    bad++; $display("FAIL state instr=%0d cyc=%0d got=%0d exp=%0d", n, k, stateCPU, e.st);
                end
                total++;
                if ({ramWe, ramClear, lcdStart, busy} !== {exp_we, exp_clr, e.ls, exp_busy}) begin
                    bad++; $display("FAIL strobes instr=%0d cyc=%0d got(we,clr,ls,busy)=%b exp=%b",
                                    n, k, {ramWe, ramClear, lcdStart, busy}, {exp_we, exp_clr, e.ls, exp_busy});
                end
                total++;
                if (error !== e.err) begin
                    bad++; $display("FAIL error instr=%0d cyc=%0d got=%b exp=%b", n, k, error, e.err);
                end
                if (k > 0) begin
                    total++;
                    if ({opcode, sinalImm, Imm, addrDst, addrSrc1, addrSrc2} !== fields_of(ins)) begin
                        bad++; $display("FAIL fields instr=%0d cyc=%0d got=%h exp=%h", n, k,
                                        {opcode, sinalImm, Imm, addrDst, addrSrc1, addrSrc2}, fields_of(ins));
                    end
                end
                send = e.snd; decoded = e.dec; calculated = e.calc; lcdDone = e.lcd;
                instruction = (k == 0) ? ins : 18'($urandom());
                @(posedge clk); #1;
            end
            total++;
            if (obs_we_n !== exp_we_n) begin
                bad++; $display("FAIL we_count instr=%0d got=%0d exp=%0d", n, obs_we_n, exp_we_n);
            end
            total++;
            if (obs_ls_n !== exp_ls_n) begin
                bad++; $display("FAIL lcdstart_count instr=%0d got=%0d exp=%0d", n, obs_ls_n, exp_ls_n);
            end
            $display("instr %0d: ins=%05h op=%0d dd=%0d dc=%0d dl=%0d held=%0d cycles=%0d err=%0d",
                     n, ins, ins[17:15], dd, dc, dl, held, q.size(), err_model);
        end
    endtask

    task automatic test_abort();
        logic [17:0] ins;
        logic [17:0] ins2;
        ins  = 18'b001_0101_0001_0010_000;
        ins2 = 18'b110_1001_0110_0011_101;
        decoded = 1'b0; calculated = 1'b0; lcdDone = 1'b0;

        // power off while in READ
        send = 1'b1; instruction = ins;
        @(posedge clk); #1;
        total++;
        if (stateCPU !== ST_DECODE) begin
            bad++; $display("FAIL abort_start got=%0d exp=%0d", stateCPU, ST_DECODE);
        end
        send = 1'b0; instruction = 18'($urandom()); decoded = 1'b1;
        @(posedge clk); #1;
        total++;
        if (stateCPU !== ST_READ) begin
            bad++; $display("FAIL abort_read got=%0d exp=%0d", stateCPU, ST_READ);
        end
        decoded = 1'b0; power = 1'b0; calculated = 1'b1; lcdDone = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({stateCPU, ramWe, ramClear, lcdStart, busy} !== {ST_OFF, 4'b0}) begin
            bad++; $display("FAIL poweroff_read got(st,we,clr,ls,busy)=%b exp=%b",
                            {stateCPU, ramWe, ramClear, lcdStart, busy}, {ST_OFF, 4'b0});
        end
        total++;
        if ({opcode, sinalImm, Imm, addrDst, addrSrc1, addrSrc2} !== fields_of(ins)) begin
            bad++; $display("FAIL fields_hold_off got=%h exp=%h",
                            {opcode, sinalImm, Imm, addrDst, addrSrc1, addrSrc2}, fields_of(ins));
        end
        power = 1'b1; calculated = 1'b0; lcdDone = 1'b0;
        @(posedge clk); #1;
        total++;
        if (stateCPU !== ST_FETCH) begin
            bad++; $display("FAIL abort_refetch got=%0d exp=%0d", stateCPU, ST_FETCH);
        end

        // power off in CALC in the same cycle calculated arrives
        send = 1'b1; instruction = ins;
        @(posedge clk); #1;
        send = 1'b0; decoded = 1'b1;
        @(posedge clk); #1;
        decoded = 1'b0;
        @(posedge clk); #1;
        total++;
        if (stateCPU !== ST_CALC) begin
            bad++; $display("FAIL abort_calc got=%0d exp=%0d", stateCPU, ST_CALC);
        end
        power = 1'b0; calculated = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({stateCPU, ramWe, ramClear, lcdStart, busy} !== {ST_OFF, 4'b0}) begin
            bad++; $display("FAIL poweroff_calc got(st,we,clr,ls,busy)=%b exp=%b",
                            {stateCPU, ramWe, ramClear, lcdStart, busy}, {ST_OFF, 4'b0});
        end
        power = 1'b1; calculated = 1'b0;
        @(posedge clk); #1;

        // reset while in CALC with the handshake ready
        send = 1'b1; instruction = ins2;
        @(posedge clk); #1;
        send = 1'b0; decoded = 1'b1;
        @(posedge clk); #1;
        decoded = 1'b0;
        @(posedge clk); #1;
        total++;
        if (stateCPU !== ST_CALC) begin
            bad++; $display("FAIL rst_calc_pre got=%0d exp=%0d", stateCPU, ST_CALC);
        end
        rst = 1'b1; calculated = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({stateCPU, ramWe, ramClear, lcdStart, busy, error} !== {ST_OFF, 5'b0}) begin
            bad++; $display("FAIL rst_calc got(st,we,clr,ls,busy,err)=%b exp=%b",
                            {stateCPU, ramWe, ramClear, lcdStart, busy, error}, {ST_OFF, 5'b0});
        end
        total++;
        if ({opcode, sinalImm, Imm, addrDst, addrSrc1, addrSrc2} !== 29'b0) begin
            bad++; $display("FAIL rst_fields got=%h exp=0", {opcode, sinalImm, Imm, addrDst, addrSrc1, addrSrc2});
        end
        rst = 1'b0; calculated = 1'b0;
        @(posedge clk); #1;
        total++;
        if (stateCPU !== ST_FETCH) begin
            bad++; $display("FAIL rst_refetch got=%0d exp=%0d", stateCPU, ST_FETCH);
        end
        $display("abort: done, total=%0d", total);
    endtask

    initial begin
        test_reset();
        test_instructions();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/module_control.md
MODULE_CONTROL -- requirements
Module: module_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum cycles spent waiting in DECODE, CALC or SHOW for the handshake input.
REQ-002 SHALL have port clk  in  1  single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port power  in  1  level; 1 = CPU on, 0 = CPU off.
REQ-005 SHALL have port send  in  1  level from the execute button; execution is triggered by its rising edge.
REQ-006 SHALL have port instruction  in  18  instruction word, with fields [17:15] opcode, [14:11] dst, [10:7] src1, [6:3] src2, [6] sign, [5:0] imm.
REQ-007 SHALL have port decoded  in  1  ALU decode-done handshake.
REQ-008 SHALL have port calculated  in  1  ALU calc-done handshake.
REQ-009 SHALL have port lcdDone  in  1  display-done handshake.
REQ-010 SHALL have port stateCPU  out  3  current state, encoded OFF=000, FETCH=001, DECODE=010, READ=011, CALC=100, SHOW=101, STORE=110.
REQ-011 SHALL have port opcode  out  3  latched opcode.
REQ-012 SHALL have port sinalImm  out  1  latched sign.
REQ-013 SHALL have port Imm  out  6  latched imm.
REQ-014 SHALL have ports addrDst, addrSrc1, addrSrc2  out  4 each  latched register addresses.
REQ-015 SHALL have port ramWe  out  1  one-cycle register-file write strobe.
REQ-016 SHALL have port ramClear  out  1  one-cycle clear-all strobe.
REQ-017 SHALL have port lcdStart  out  1  one-cycle display start strobe.
REQ-018 SHALL have port busy  out  1  1 in any state other than OFF and FETCH.
REQ-019 SHALL have port error  out  1  sticky timeout flag.

Function
REQ-020 SHALL detect the send rising edge as send=1 while the registered previous send=0; an edge seen outside FETCH is discarded, not queued.
REQ-021 In OFF: stay while power=0; go to FETCH when power=1.
REQ-022 In FETCH: on a send edge, latch all instruction fields into the output registers, clear error, and go to DECODE.
REQ-023 In DECODE: go to READ on the first cycle with decoded=1.
REQ-024 In READ: stay exactly 1 cycle (register-file read latency), then go to CALC.
REQ-025 In CALC: on calculated=1, go to SHOW if opcode=111 (DISPLAY), otherwise go to STORE.
REQ-026 In STORE: stay exactly 1 cycle.
REQ-026a STORE strobes: ramClear=1 if opcode=110 (CLEAR), otherwise ramWe=1; never both.
REQ-026b STORE exit: go to SHOW.
REQ-027 In SHOW: assert lcdStart for the first cycle in SHOW only; go to FETCH on lcdDone=1.
REQ-027a lcdDone arriving in the same cycle as lcdStart SHALL be accepted.
REQ-028 Wait counter: SHALL clear on every state entry and increment each cycle spent in DECODE, CALC or SHOW.
REQ-028a Timeout: when the counter reaches TIMEOUT with the handshake still 0, go to FETCH and set error=1.
REQ-028b Handshake priority: a handshake asserted in the same cycle as the timeout wins, and error stays 0.
REQ-029 power=0 in any state SHALL force OFF on the next edge. This has priority over every handshake and timeout. ramWe, ramClear and lcdStart SHALL be 0 in that cycle.
REQ-030 Latched fields SHALL hold from FETCH exit until the next FETCH exit, and are unchanged by OFF.
REQ-031 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-032 On rst=1 at a clk edge: stateCPU=OFF; opcode, sinalImm, Imm, addrDst, addrSrc1, addrSrc2 = 0; ramWe=0; ramClear=0; lcdStart=0; busy=0; error=0; wait counter=0; previous-send register=0.
REQ-033 rst SHALL take priority over power and all other inputs. rst asserted mid-instruction SHALL abort it with no strobe emitted in that cycle.
REQ-034 After rst deasserts with power=1, the block SHALL reach FETCH one cycle later.

Verification
REQ-035 ADD path: instruction 001_0011_0001_0010_xxx, decoded and calculated driven 2 cycles after each state entry, lcdDone 3 cycles after lcdStart. Required: states FETCH,DECODE,READ,CALC,STORE,SHOW,FETCH; ramWe=1 for exactly 1 cycle with addrDst=3; lcdStart once.
REQ-036 DISPLAY path: opcode=111. Required: CALC goes directly to SHOW; ramWe=0 and ramClear=0 throughout.
REQ-037 CLEAR path: opcode=110. Required: ramClear=1 for 1 cycle in STORE; ramWe stays 0.
REQ-038 Timeout: calculated held 0. Required: after TIMEOUT=15 cycles in CALC, return to FETCH with error=1. A following send edge clears error.
REQ-039 Send while busy: send held 1 through an entire instruction. Required: exactly one instruction executes, and a new edge is needed to start the next.
REQ-040 Abort: power=0 during READ, then rst=1 during CALC. Required: OFF on the next edge in each case, no strobes, and all outputs at the REQ-032 values after rst.
